alu_writeback: RTL
==================

Name: alu_writeback

Overview:
- Commit end of the ALU datapath. It consumes the instruction word, 32-bit result and n/z/c/v flags that the ALU produces, and holds the architectural state the ALU depends on.
- It evaluates the instruction condition against the stored CPSR flags. It writes the result into a 16x32 register file, updates the CPSR and supplies operands back to the issue side through two read ports.
- One capture stage plus one commit stage; commits strictly in order, one per cycle.

Parameters:
- CNT_W, 16, width of the retire and skip counters (wrap-around).
- RF_RST, 32'h0000_0000, reset value of every register-file entry.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  ALU output is valid this cycle
- in_ready  out  1  unit can accept this cycle
- instr  in  32  instruction word that travelled with the ALU op
- result  in  32  ALU result r
- flag_n, flag_z, flag_c, flag_v  in  1 each  ALU flags
- flush  in  1  discard any pending (uncommitted) instruction
- raddr_a, raddr_b  in  4 each  register read addresses
- rdata_a, rdata_b  out  32 each  register read data (combinational)
- cpsr  out  4  architectural flags {N,Z,C,V}
- retire_cnt  out  CNT_W  committed instructions whose condition passed
- skip_cnt  out  CNT_W  instructions dropped because their condition failed

Behaviour:
- Instruction fields (decided):
  - cond = instr[31:28], opcode = instr[27:24], S = instr[23], rd = instr[22:19].
  - Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 ORR, 5 EOR, 6 CMP, 7 MOV, 8 MVN, 9-15 NOP.
- Reset (asynchronous): all rf entries = RF_RST; cpsr = 0; pend_valid = 0; retire_cnt = 0; skip_cnt = 0.
  - Reset asserted mid-operation discards any pending instruction; nothing is committed.
- Handshake:
  - in_ready = !flush.
  - An instruction is accepted on a cycle where in_valid && in_ready. Back-to-back accepts are allowed every cycle.
- Capture: on accept, latch instr, result and flags into the pend registers and set pend_valid = 1. With no accept, pend_valid = 0 next cycle.
- Commit (cycle after accept, when pend_valid = 1):
  - Condition is evaluated against the current cpsr using ARM encodings 0-14 (EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL). cond = 15 never passes.
  - Pass and opcode 0-5, 7 or 8: rf[rd] <= pend_result. If S = 1, also cpsr <= pend flags.
  - Pass and opcode 6: no rf write; cpsr <= pend flags regardless of S.
  - Pass and opcode 9-15: no rf write, no flag update.
  - Every pass increments retire_cnt by 1.
  - Fail: no rf or cpsr change; skip_cnt increments by 1.
- Ordering: the condition of instruction k+1 sees the cpsr as updated by instruction k, because commits are consecutive edges.
- Latency: rf and cpsr are updated on the second rising edge after the accepting edge's cycle, i.e. one cycle after capture.
- Flush:
  - flush = 1 clears pend_valid at the next edge; the pending instruction is neither committed nor counted.
  - in_ready is low, so no new accept can occur in the same cycle.
- Read ports: rdata_x = rf[raddr_x], combinational.
- Counters wrap from 2^CNT_W-1 to 0 with no saturation.

Optional Feature:
- Macro: ALU_WB_BYPASS_EN.
- Defined: if pend_valid, the condition passes, the opcode writes rd, and raddr_x == pend rd, then rdata_x = pend_result in the commit cycle. This gives zero-bubble read-after-write.
- Undefined: rdata_x always shows the rf contents. The issue side must wait one extra cycle for the new value.

Decomposition:
- Package alu_wb_pkg holds:
  - Opcode constants OP_ADD..OP_MVN.
  - Condition-code constants COND_EQ..COND_NV.
  - Instruction field bit positions.
  - A cpsr struct {n,z,c,v}.
- Sub-module cond_eval: combinational, (cond[3:0], cpsr[3:0]) -> pass. It is instantiated once in the commit stage.

Test Plan:
- Reset, then read all addresses: rdata = 0, cpsr = 0, both counters = 0, in_ready = 1.
- Accept MOV AL (instr 32'hE7180000, rd=3), result 32'h0000_0005: two edges later rf[3] = 5; retire_cnt = 1; cpsr unchanged (S=0).
- Back-to-back: CMP AL with flags Z=1 (cpsr -> 4'b0100), then ADD EQ rd=1 result 7, then ADD NE rd=2 result 9:
  - rf[1] = 7, rf[2] unchanged.
  - retire_cnt = 2, skip_cnt = 1.
- cond = 15 with in_valid = 1 for 3 cycles: skip_cnt += 3; no rf or cpsr change.
- Accept ADD rd=4, then assert flush in the following cycle: rf[4] unchanged, counters unchanged, in_ready = 0 during flush.
- Bypass: with ALU_WB_BYPASS_EN defined, in the commit cycle of MOV rd=6 result 32'hDEAD_BEEF with raddr_a = 6, rdata_a = 32'hDEAD_BEEF. With the macro undefined, rdata_a shows the old value that cycle and the new value on the next.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// rtl/alu_wb_pkg.sv - shared opcode, condition and field definitions for alu_writeback
package alu_wb_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_ORR = 4'd4;
    localparam logic [3:0] OP_EOR = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_MVN = 4'd8;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int COND_MSB = 31;
    localparam int COND_LSB = 28;
    localparam int OP_MSB   = 27;
    localparam int OP_LSB   = 24;
    localparam int S_BIT    = 23;
    localparam int RD_MSB   = 22;
    localparam int RD_LSB   = 19;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } cpsr_t;

    function automatic logic op_writes_rd(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_ORR, OP_EOR, OP_MOV, OP_MVN};
    endfunction

endpackage

// File: rtl/alu_writeback_cond_eval.sv
// rtl/alu_writeback_cond_eval.sv - ARM condition-code check against the stored flags
module cond_eval
    import alu_wb_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] cpsr,
    output logic       pass
);

    cpsr_t f;
    assign f = cpsr;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = f.z;
            COND_NE: pass = !f.z;
            COND_CS: pass = f.c;
            COND_CC: pass = !f.c;
            COND_MI: pass = f.n;
            COND_PL: pass = !f.n;
            COND_VS: pass = f.v;
            COND_VC: pass = !f.v;
            COND_HI: pass = f.c && !f.z;
            COND_LS: pass = !f.c || f.z;
            COND_GE: pass = (f.n == f.v);
            COND_LT: pass = (f.n != f.v);
            COND_GT: pass = !f.z && (f.n == f.v);
            COND_LE: pass = f.z || (f.n != f.v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - capture/commit stage: register file, CPSR, retire/skip counters
// Optional ALU_WB_BYPASS_EN forwards the committing result onto the read ports.
module alu_writeback
    import alu_wb_pkg::*;
#(
    parameter int          CNT_W  = 16,
    parameter logic [31:0] RF_RST = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      result,
    input  logic             flag_n,
    input  logic             flag_z,
    input  logic             flag_c,
    input  logic             flag_v,
    input  logic             flush,
    input  logic [3:0]       raddr_a,
    input  logic [3:0]       raddr_b,
    output logic [31:0]      rdata_a,
    output logic [31:0]      rdata_b,
    output logic [3:0]       cpsr,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    logic [31:0] rf [16];
    logic        pend_valid;
    logic [3:0]  pend_cond;
    logic [3:0]  pend_op;
    logic        pend_s;
    logic [3:0]  pend_rd;
    logic [31:0] pend_result;
    cpsr_t       pend_flags;
    cpsr_t       cpsr_q;

    logic accept;
    logic cond_pass;
    logic commit;
    logic do_write;
    logic do_flags;
    logic unused_instr;

    assign unused_instr = ^instr[RD_LSB-1:0];

    assign in_ready = !flush;
    assign accept   = in_valid && in_ready;
    assign cpsr     = cpsr_q;

    cond_eval u_cond_eval (
        .cond (pend_cond),
        .cpsr (cpsr_q),
        .pass (cond_pass)
    );

    // A flush in the commit cycle kills the pending op before it touches any state.
    assign commit   = pend_valid && !flush;
    assign do_write = commit && cond_pass && op_writes_rd(pend_op);
    assign do_flags = commit && cond_pass &&
                      ((pend_op == OP_CMP) || (pend_s && op_writes_rd(pend_op)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_cond   <= '0;
            pend_op     <= '0;
            pend_s      <= 1'b0;
            pend_rd     <= '0;
            pend_result <= '0;
            pend_flags  <= '0;
        end else begin
            pend_valid <= accept;
            if (accept) begin
                pend_cond   <= instr[COND_MSB:COND_LSB];
                pend_op     <= instr[OP_MSB:OP_LSB];
                pend_s      <= instr[S_BIT];
                pend_rd     <= instr[RD_MSB:RD_LSB];
                pend_result <= result;
                pend_flags  <= '{n: flag_n, z: flag_z, c: flag_c, v: flag_v};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                rf[i] <= RF_RST;
            end
            cpsr_q     <= '0;
            retire_cnt <= '0;
            skip_cnt   <= '0;
        end else begin
            if (do_write) begin
                rf[pend_rd] <= pend_result;
            end
            if (do_flags) begin
                cpsr_q <= pend_flags;
            end
            if (commit) begin
                if (cond_pass) begin
                    retire_cnt <= retire_cnt + 1'b1;
                end else begin
                    skip_cnt <= skip_cnt + 1'b1;
                end
            end
        end
    end

`ifdef ALU_WB_BYPASS_EN
    always_comb begin
        rdata_a = rf[raddr_a];
        rdata_b = rf[raddr_b];
        if (do_write && (raddr_a == pend_rd)) begin
            rdata_a = pend_result;
        end
        if (do_write && (raddr_b == pend_rd)) begin
            rdata_b = pend_result;
        end
    end
`else
    assign rdata_a = rf[raddr_a];
    assign rdata_b = rf[raddr_b];
`endif

endmodule
